// File: rtl/commit_trace_unit.sv
// Commit trace buffer: queues GRF/DM architectural write events in program order
// and drains them oldest-first through a valid/ready stream, counting overflow drops.
module commit_trace_unit #(
    parameter int unsigned DEPTH   = 16,
    parameter bit          DROP_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        grf_we,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wdata,
    input  logic        dm_we,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic        trace_kind,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        almost_full,
    output logic [15:0] drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [AW+1:0] ONE_W   = (AW+2)'(1);
    localparam logic [AW+1:0] TWO_W   = (AW+2)'(2);

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [15:0]   drop_q, drop_d;

    logic [AW:0]   count;
    logic [AW+1:0] free;
    logic          pop;
    logic          grf_acc;
    logic          grf_ok;
    logic          dm_ok;
    logic [1:0]    n_drop;
    logic [16:0]   drop_sum;
    logic [AW-1:0] dm_idx;
    entry_t        grf_e;
    entry_t        dm_e;
    entry_t        head;

    assign count = wr_q - rd_q;
    assign pop   = (count != '0) && trace_ready;

    always_comb begin
        grf_e    = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata};
        dm_e     = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};
        free     = DEPTH_W - (AW+2)'(count) + (AW+2)'(pop);
        grf_acc  = grf_we && !(DROP_R0 && (grf_addr == '0));
        grf_ok   = grf_acc && (free >= ONE_W);
        // A refused GRF push also blocks DM so the older write is never overtaken.
        dm_ok    = dm_we && (grf_acc ? (grf_ok && (free >= TWO_W)) : (free >= ONE_W));
        n_drop   = {1'b0, grf_acc && !grf_ok} + {1'b0, dm_we && !dm_ok};
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
        dm_idx   = wr_q[AW-1:0] + AW'(grf_ok);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (grf_ok) mem_d[wr_q[AW-1:0]] = grf_e;
        if (dm_ok)  mem_d[dm_idx]       = dm_e;

        wr_d = wr_q + (AW+1)'(grf_ok) + (AW+1)'(dm_ok);
        rd_d = rd_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            drop_q <= drop_d;
        end
    end

    // Head is read straight from storage flops, so outputs depend only on state.
    assign head        = mem_q[rd_q[AW-1:0]];
    assign trace_valid = (count != '0);
    assign trace_kind  = head.kind;
    assign trace_pc    = head.pc;
    assign trace_addr  = head.addr;
    assign trace_data  = head.data;
    assign almost_full = (DEPTH_W - (AW+2)'(count)) < TWO_W;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed scoreboard bench for commit_trace_unit: driver queues expected entries,
// a negedge monitor pops and compares every handshake.
module tb_commit_trace_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        grf_we = 1'b0;
    logic [31:0] grf_pc = '0;
    logic [4:0]  grf_addr = '0;
    logic [31:0] grf_wdata = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_pc = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic        trace_kind;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        almost_full;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [96:0] sb[$];

    commit_trace_unit #(.DEPTH(16), .DROP_R0(1'b1)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_kind(trace_kind), .trace_pc(trace_pc), .trace_addr(trace_addr),
        .trace_data(trace_data), .almost_full(almost_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake completes at the next rising edge; inputs are stable at negedge.
    always @(negedge clk) begin
        if (reset && trace_valid && trace_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_entry: got %h expected none",
                         {trace_kind, trace_pc, trace_addr, trace_data});
            end else begin
                chk("entry", {trace_kind, trace_pc, trace_addr, trace_data}, sb.pop_front());
            end
        end
    end

    task automatic drive(input logic gw, input logic [31:0] gpc, input logic [4:0] ga,
                         input logic [31:0] gd, input logic dw, input logic [31:0] dpc,
                         input logic [31:0] dad, input logic [31:0] dd,
                         input logic eg, input logic ed);
        grf_we = gw; grf_pc = gpc; grf_addr = ga; grf_wdata = gd;
        dm_we = dw; dm_pc = dpc; dm_addr = dad; dm_wdata = dd;
        if (eg) sb.push_back({1'b0, gpc, {27'b0, ga}, gd});
        if (ed) sb.push_back({1'b1, dpc, dad, dd});
        @(posedge clk); #1;
        grf_we = 1'b0;
        dm_we = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 97'(trace_valid), 97'(0));
        chk("reset_af", 97'(almost_full), 97'(0));
        chk("reset_drop", 97'(drop_cnt), 97'(0));
        chk("reset_head", {trace_kind, trace_pc, trace_addr, trace_data}, 97'(0));
        #3 reset = 1'b1;
        @(posedge clk); #1;

        // 1: single GRF write, immediate visibility and pop
        trace_ready = 1'b1;
        drive(1, 32'h3000, 5'd8, 32'h1234, 0, '0, '0, '0, 1, 0);
        chk("t1_valid_after_push", 97'(trace_valid), 97'(1));
        @(posedge clk); #1;
        chk("t1_valid_after_pop", 97'(trace_valid), 97'(0));
        drain("t1");

        // 2: same-cycle GRF + DM, GRF first
        drive(1, 32'h3004, 5'd9, 32'hAAAA_0001, 1, 32'h3008, 32'h10, 32'hBBBB_0002, 1, 1);
        drain("t2");

        // 3: write to $0 is not traced
        drive(1, 32'h300C, 5'd0, 32'hDEAD, 0, '0, '0, '0, 0, 0);
        chk("t3_valid", 97'(trace_valid), 97'(0));
        chk("t3_drop", 97'(drop_cnt), 97'(0));
        drain("t3");

        // 4: fill with ready low, then overflow with GRF+DM
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h4000 + 32'(4 * i), 5'(i + 1), 32'h100 + 32'(i), 0, '0, '0, '0, 1, 0);
            chk($sformatf("t4_af_%0d", i), 97'(almost_full), 97'(i + 1 >= 15));
        end
        drive(1, 32'h4100, 5'd20, 32'hFFFF, 1, 32'h4104, 32'h20, 32'hEEEE, 0, 0);
        chk("t4_drop", 97'(drop_cnt), 97'(2));
        chk("t4_head_pc", 97'(trace_pc), 97'(32'h4000));
        chk("t4_valid", 97'(trace_valid), 97'(1));

        // 5: full with pop + push each cycle, wraps pointers
        trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1, 32'h5000 + 32'(4 * i), 5'(i % 31 + 1), 32'h200 + 32'(i), 0, '0, '0, '0, 1, 0);
        end
        chk("t5_drop", 97'(drop_cnt), 97'(2));
        drain("t5");
        chk("t5_empty", 97'(trace_valid), 97'(0));
        chk("t5_af", 97'(almost_full), 97'(0));

        // 6: reset while 8 entries queued
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h6000 + 32'(4 * i), 5'd3, 32'h300 + 32'(i), 0, '0, '0, '0, 0, 0);
        end
        chk("t6_valid_before", 97'(trace_valid), 97'(1));
        #3 reset = 1'b0;
        #1;
        chk("t6_valid_in_reset", 97'(trace_valid), 97'(0));
        chk("t6_drop_in_reset", 97'(drop_cnt), 97'(0));
        chk("t6_head_in_reset", {trace_kind, trace_pc, trace_addr, trace_data}, 97'(0));
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        trace_ready = 1'b1;
        chk("t6_valid_after_release", 97'(trace_valid), 97'(0));
        drive(0, '0, '0, '0, 1, 32'h7000, 32'h40, 32'h7777, 0, 1);
        drive(1, 32'h7004, 5'd31, 32'h8888, 0, '0, '0, '0, 1, 0);
        drain("t6");
        chk("t6_drop_final", 97'(drop_cnt), 97'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
